// File: rtl/multi_tick_gen_pkg.sv
// Shared helpers for the multi-channel microsecond tick generator.
package multi_tick_gen_pkg;

   localparam int unsigned US_PER_S = 1_000_000;

   // Prescaler counter width; a one-state counter still needs one bit.
   function automatic int unsigned presc_w(input int unsigned mhz);
      return (mhz > 1) ? $clog2(mhz) : 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLK down to a registered one-cycle strobe every microsecond.
module tick_prescaler
   import multi_tick_gen_pkg::*;
#(
   parameter int unsigned CLOCK_SPEED_MHZ = 12
) (
   input  logic CLK,
   input  logic RST,
   output logic us_tick
);

   localparam int unsigned     CNT_W = presc_w(CLOCK_SPEED_MHZ);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCK_SPEED_MHZ - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count   <= '0;
         us_tick <= 1'b0;
      end else begin
         us_tick <= (count == LAST);
         count   <= (count == LAST) ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/multi_tick_gen.sv
// N independent period timers sharing one microsecond timebase; each emits a
// square wave and a one-cycle event pulse.
module multi_tick_gen
   import multi_tick_gen_pkg::*;
#(
   parameter int unsigned CLOCK_SPEED_MHZ   = 12,
   parameter int unsigned CHANNELS          = 4,
   parameter int unsigned PERIOD_W          = 20,
   parameter int unsigned DEFAULT_PERIOD_US = 500000
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [CHANNELS-1:0] en,
   input  logic [CHANNELS-1:0] load,
   input  logic [PERIOD_W-1:0] period_in,
   output logic                us_tick,
   output logic [CHANNELS-1:0] sq_out,
   output logic [CHANNELS-1:0] pulse_out
);

   localparam logic [PERIOD_W-1:0] DEF_PERIOD = PERIOD_W'(DEFAULT_PERIOD_US);

   tick_prescaler #(
      .CLOCK_SPEED_MHZ(CLOCK_SPEED_MHZ)
   ) u_prescaler (
      .CLK    (CLK),
      .RST    (RST),
      .us_tick(us_tick)
   );

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [PERIOD_W-1:0] period_reg;
      logic [PERIOD_W-1:0] count;
      logic                sq_r;
      logic                pulse_r;

      // Load beats disable beats idle beats counting; count never reaches period_reg.
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            period_reg <= DEF_PERIOD;
            count      <= '0;
            sq_r       <= 1'b0;
            pulse_r    <= 1'b0;
         end else begin
            pulse_r <= 1'b0;
            if (load[i]) begin
               period_reg <= period_in;
               count      <= '0;
               sq_r       <= 1'b0;
            end else if (!en[i] || (period_reg == '0)) begin
               count <= '0;
               sq_r  <= 1'b0;
            end else if (us_tick) begin
               if (count == period_reg - PERIOD_W'(1)) begin
                  count   <= '0;
                  sq_r    <= ~sq_r;
                  pulse_r <= 1'b1;
               end else begin
                  count <= count + PERIOD_W'(1);
               end
            end
         end
      end

      assign sq_out[i]    = sq_r;
      assign pulse_out[i] = pulse_r;
   end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen: hand-computed event schedules per channel.
module tb_multi_tick_gen;

   localparam int unsigned MHZ  = 12;
   localparam int unsigned CH   = 4;
   localparam int unsigned PW   = 20;
   // Short default so the reset-value readback fits in a brief run.
   localparam int unsigned DEFP = 5;

   logic          CLK;
   logic          RST;
   logic [CH-1:0] en;
   logic [CH-1:0] load;
   logic [PW-1:0] period_in;
   logic          us_tick;
   logic [CH-1:0] sq_out;
   logic [CH-1:0] pulse_out;

   int n_checks;
   int n_err;
   int cyc;

   multi_tick_gen #(
      .CLOCK_SPEED_MHZ  (MHZ),
      .CHANNELS         (CH),
      .PERIOD_W         (PW),
      .DEFAULT_PERIOD_US(DEFP)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .en       (en),
      .load     (load),
      .period_in(period_in),
      .us_tick  (us_tick),
      .sq_out   (sq_out),
      .pulse_out(pulse_out)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   function automatic logic ev(input int k, input int first, input int per);
      return (k >= first) && (((k - first) % per) == 0);
   endfunction

   function automatic logic sqf(input int k, input int first, input int per);
      return (k >= first) && ((((k - first) / per) % 2) == 0);
   endfunction

   // Expected {sq_out, pulse_out} after edge k of the first run.
   function automatic logic [7:0] sched(input int k);
      logic [3:0] p;
      logic [3:0] s;
      p = '0;
      s = '0;
      if (k >= 61 && k <= 62) begin
         p[0] = (k == 61);
         s[0] = 1'b1;
      end else if (k >= 63 && k <= 312) begin
         p[0] = ev(k, 97, 36);
         s[0] = sqf(k, 97, 36);
      end else if (k >= 313 && k <= 345) begin
         p[0] = ev(k, 337, 24);
         s[0] = sqf(k, 337, 24);
      end else if (k >= 362) begin
         p[0] = ev(k, 385, 24);
         s[0] = sqf(k, 385, 24);
      end
      if (k >= 171) begin
         p[1] = ev(k, 181, 12);
         s[1] = sqf(k, 181, 12);
      end
      if (k >= 241) begin
         p[2] = ev(k, 265, 24);
         s[2] = sqf(k, 265, 24);
      end
      return {s, p};
   endfunction

   initial begin
      logic [7:0] exp_v;
      n_checks  = 0;
      n_err     = 0;
      cyc       = 0;
      RST       = 1'b1;
      en        = '0;
      load      = '0;
      period_in = '0;

      repeat (5) step();
      check("rst_us_tick", 32'(us_tick), 32'(0));
      check("rst_sq", 32'(sq_out), 32'(0));
      check("rst_pulse", 32'(pulse_out), 32'(0));

      RST = 1'b0;
      en  = 4'b0001;
      cyc = 0;
      for (int k = 1; k <= 400; k++) begin
         step();
         exp_v = sched(cyc);
         check("us_tick", 32'(us_tick), 32'(cyc % 12 == 0));
         check("pulse", 32'(pulse_out), 32'(exp_v[3:0]));
         check("sq", 32'(sq_out), 32'(exp_v[7:4]));
         case (cyc)
            62:  begin load = 4'b0001; period_in = 20'd3; end
            63:  load = 4'b0000;
            170: begin load = 4'b0010; period_in = 20'd1; en = 4'b0111; end
            171: begin load = 4'b0100; period_in = 20'd0; end
            172: load = 4'b0000;
            240: begin load = 4'b0100; period_in = 20'd2; end
            241: load = 4'b0000;
            312: begin load = 4'b0001; period_in = 20'd2; end
            313: load = 4'b0000;
            345: en = 4'b0110;
            361: en = 4'b0111;
            default: ;
         endcase
      end

      // Asynchronous reset between edges, outputs must clear before the next edge.
      #2;
      RST = 1'b1;
      #1;
      check("async_us_tick", 32'(us_tick), 32'(0));
      check("async_sq", 32'(sq_out), 32'(0));
      check("async_pulse", 32'(pulse_out), 32'(0));
      step();
      check("held_rst_all", 32'({us_tick, sq_out, pulse_out}), 32'(0));

      RST = 1'b0;
      cyc = 0;
      for (int k = 1; k <= 62; k++) begin
         step();
         check("re_us_tick", 32'(us_tick), 32'(cyc % 12 == 0));
         check("re_pulse", 32'(pulse_out), (cyc == 61) ? 32'h7 : 32'h0);
         check("re_sq", 32'(sq_out), (cyc >= 61) ? 32'h7 : 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
